// File: rtl/stream_mux4_rr.sv
// 4:1 round-robin valid/ready stream merger with a registered, source-tagged output beat.
// Optional packet lock (in_last/out_last, grant held until a last beat): define STREAM_MUX4_PKT_LOCK_EN.
module stream_mux4_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
`ifdef STREAM_MUX4_PKT_LOCK_EN
  input  logic [3:0]         in_last,
  output logic               out_last,
`endif
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic [1:0]       ptr;
  logic [3:0]       grant;
  logic [1:0]       gidx;
  logic             can_load;
  logic             load;
  logic             ptr_upd;
  logic [WIDTH-1:0] src_data [4];

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign src_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Output register can take a new beat when empty or being drained this cycle.
  assign can_load = !out_valid || out_ready;

  // Round-robin search starting at ptr; the first valid source wins.
  logic [3:0] rr_grant;
  logic [1:0] rr_idx;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    rr_grant = '0;
    rr_idx   = ptr;
    found    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && in_valid[idx]) begin
        rr_grant[idx] = 1'b1;
        rr_idx        = idx;
        found         = 1'b1;
      end
    end
  end

`ifdef STREAM_MUX4_PKT_LOCK_EN
  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t state, state_next;
  logic [1:0]  lock_src, lock_src_next;

  // While locked, only the owning source may be granted, even when it is idle.
  always_comb begin
    grant         = rr_grant;
    gidx          = rr_idx;
    state_next    = state;
    lock_src_next = lock_src;
    if (state == ST_LOCKED) begin
      grant           = '0;
      grant[lock_src] = in_valid[lock_src];
      gidx            = lock_src;
    end
    if (load) begin
      lock_src_next = gidx;
      state_next    = in_last[gidx] ? ST_ARB : ST_LOCKED;
    end
  end

  assign ptr_upd = load && in_last[gidx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_ARB;
      lock_src <= '0;
      out_last <= 1'b0;
    end else begin
      state    <= state_next;
      lock_src <= lock_src_next;
      if (load) out_last <= in_last[gidx];
    end
  end
`else
  assign grant   = rr_grant;
  assign gidx    = rr_idx;
  assign ptr_upd = load;
`endif

  assign in_ready = grant & {4{can_load && rst_n}};
  assign load     = |in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= src_data[gidx];
        out_sel   <= gidx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (ptr_upd) ptr <= gidx + 2'd1;
    end
  end

endmodule

// File: tb/tb_stream_mux4_rr.sv
// Self-checking bench for stream_mux4_rr: directed vector table, random scoreboard run,
// and the packet-lock sequence when STREAM_MUX4_PKT_LOCK_EN is defined.
module tb_stream_mux4_rr;
  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;
`ifdef STREAM_MUX4_PKT_LOCK_EN
  logic [3:0]         in_last;
  logic               out_last;
`endif

  always #5 clk = ~clk;

  stream_mux4_rr #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef STREAM_MUX4_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbiter: rotate the valid vector by the pointer and take the lowest set bit.
  function automatic logic [3:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [7:0] dbl;
    logic [3:0] win;
    dbl = {v, v} >> p;
    win = '0;
    for (int j = 3; j >= 0; j--)
      if (dbl[j]) win = 4'b0001 << ((j + int'(p)) % 4);
    return win;
  endfunction

  typedef struct {
    logic        rst_n;
    logic [3:0]  iv;
    logic        ordy;
    logic [31:0] d;
    logic [3:0]  eir;
    logic        eov;
    logic [1:0]  esel;
    logic [7:0]  edat;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] iv, input logic o, input logic [31:0] d,
                              input logic [3:0] eir, input logic eov, input logic [1:0] esel,
                              input logic [7:0] edat);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.ordy = o; v.d = d;
    v.eir = eir; v.eov = eov; v.esel = esel; v.edat = edat;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int idx);
    rst_n     = v.rst_n;
    in_valid  = v.iv;
    out_ready = v.ordy;
    in_data   = v.d;
    @(negedge clk);
    check($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'(v.eir));
    @(posedge clk); #1;
    check($sformatf("vec%0d out_valid", idx), 32'(out_valid), 32'(v.eov));
    check($sformatf("vec%0d out_sel", idx), 32'(out_sel), 32'(v.esel));
    check($sformatf("vec%0d out_data", idx), 32'(out_data), 32'(v.edat));
  endtask

  // Scoreboard state for the random run.
  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] d;
  } beat_t;

  beat_t      q[$];
  logic [7:0] sdata [4];
  logic [3:0] pend;
  logic [1:0] mptr;
  logic       mov;

  task automatic rnd_cycle(input bit drain);
    logic [3:0] eir;
    logic [3:0] ir_s;
    beat_t      b;
    for (int s = 0; s < 4; s++)
      if (!drain && !pend[s] && $urandom_range(0, 2) == 0) begin
        pend[s]  = 1'b1;
        sdata[s] = 8'($urandom);
      end
    in_valid = pend;
    for (int s = 0; s < 4; s++) in_data[s*WIDTH +: WIDTH] = sdata[s];
    out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    @(negedge clk);
    eir  = (!mov || out_ready) ? rr_pick(in_valid, mptr) : 4'b0000;
    ir_s = in_ready;
    check("rnd in_ready", 32'(ir_s), 32'(eir));
    check("rnd out_valid", 32'(out_valid), 32'(mov));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("rnd unexpected beat", 32'(q.size()), 32'd1);
      end else begin
        b = q.pop_front();
        check("rnd out_sel", 32'(out_sel), 32'(b.sel));
        check("rnd out_data", 32'(out_data), 32'(b.d));
      end
    end
    if (|eir) begin
      for (int k = 0; k < 4; k++)
        if (eir[k]) begin
          q.push_back({2'(k), sdata[k]});
          mptr = 2'(k + 1);
        end
      mov = 1'b1;
    end else if (out_ready) begin
      mov = 1'b0;
    end
    @(posedge clk); #1;
    pend = pend & ~ir_s;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
  endtask

`ifdef STREAM_MUX4_PKT_LOCK_EN
  task automatic lock_step(input logic [3:0] iv, input logic [3:0] lst, input logic [3:0] eir,
                           input logic eov, input logic [1:0] esel, input logic elast, input int idx);
    in_valid  = iv;
    in_last   = lst;
    in_data   = 32'h13121110;
    out_ready = 1'b1;
    @(negedge clk);
    check($sformatf("lock%0d in_ready", idx), 32'(in_ready), 32'(eir));
    @(posedge clk); #1;
    check($sformatf("lock%0d out_valid", idx), 32'(out_valid), 32'(eov));
    check($sformatf("lock%0d out_sel", idx), 32'(out_sel), 32'(esel));
    check($sformatf("lock%0d out_last", idx), 32'(out_last), 32'(elast));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [31:0] dd;
    logic [31:0] da;
    int   guard;
    dd = 32'h13121110;
    da = 32'h13A51110;
`ifdef STREAM_MUX4_PKT_LOCK_EN
    in_last = 4'hF;
`endif
    // reset held with all sources valid
    repeat (3) tbl.push_back(mk(1'b0, 4'hF, 1'b1, dd, 4'h0, 1'b0, 2'd0, 8'h00));
    // release and full contention: 0,1,2,3,0,1,2,3
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h1, 1'b1, 2'd0, 8'h10));
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h2, 1'b1, 2'd1, 8'h11));
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h4, 1'b1, 2'd2, 8'h12));
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h8, 1'b1, 2'd3, 8'h13));
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h1, 1'b1, 2'd0, 8'h10));
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h2, 1'b1, 2'd1, 8'h11));
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h4, 1'b1, 2'd2, 8'h12));
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h8, 1'b1, 2'd3, 8'h13));
    // back-pressure while holding beat 8'h11, then no-bubble reload
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h1, 1'b1, 2'd0, 8'h10));
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h2, 1'b1, 2'd1, 8'h11));
    repeat (4) tbl.push_back(mk(1'b1, 4'hF, 1'b0, dd, 4'h0, 1'b1, 2'd1, 8'h11));
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h4, 1'b1, 2'd2, 8'h12));
    // pointer wrap from 3 to 0
    tbl.push_back(mk(1'b1, 4'h9, 1'b1, dd, 4'h8, 1'b1, 2'd3, 8'h13));
    tbl.push_back(mk(1'b1, 4'h9, 1'b1, dd, 4'h1, 1'b1, 2'd0, 8'h10));
    // single source 2, twice; pointer then sits at 3
    tbl.push_back(mk(1'b1, 4'h4, 1'b1, da, 4'h4, 1'b1, 2'd2, 8'hA5));
    tbl.push_back(mk(1'b1, 4'h4, 1'b1, da, 4'h4, 1'b1, 2'd2, 8'hA5));
    tbl.push_back(mk(1'b1, 4'hF, 1'b1, dd, 4'h8, 1'b1, 2'd3, 8'h13));
    // idle cycles drain the register and leave the pointer at 0
    tbl.push_back(mk(1'b1, 4'h0, 1'b1, dd, 4'h0, 1'b0, 2'd3, 8'h13));
    tbl.push_back(mk(1'b1, 4'h0, 1'b0, dd, 4'h0, 1'b0, 2'd3, 8'h13));
    tbl.push_back(mk(1'b1, 4'h6, 1'b1, dd, 4'h2, 1'b1, 2'd1, 8'h11));
    // mid-stream reset drops the held beat and returns the pointer to 0
    tbl.push_back(mk(1'b0, 4'hF, 1'b0, dd, 4'h0, 1'b0, 2'd0, 8'h00));
    tbl.push_back(mk(1'b1, 4'h6, 1'b1, dd, 4'h2, 1'b1, 2'd1, 8'h11));
    // empty register accepts even with out_ready low, then stalls
    tbl.push_back(mk(1'b1, 4'h0, 1'b1, dd, 4'h0, 1'b0, 2'd1, 8'h11));
    tbl.push_back(mk(1'b1, 4'h8, 1'b0, dd, 4'h8, 1'b1, 2'd3, 8'h13));
    tbl.push_back(mk(1'b1, 4'h8, 1'b0, dd, 4'h0, 1'b1, 2'd3, 8'h13));
    tbl.push_back(mk(1'b1, 4'h8, 1'b1, dd, 4'h8, 1'b1, 2'd3, 8'h13));

    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

    // random traffic against the scoreboard
    do_reset();
    pend = '0;
    mptr = '0;
    mov  = 1'b0;
    for (int s = 0; s < 4; s++) sdata[s] = '0;
    for (int c = 0; c < 400; c++) rnd_cycle(1'b0);
    guard = 0;
    while ((pend != 0 || mov) && guard < 20) begin
      rnd_cycle(1'b1);
      guard++;
    end
    check("drain pending sources", 32'(pend), 32'd0);
    check("drain scoreboard empty", 32'(q.size()), 32'd0);

`ifdef STREAM_MUX4_PKT_LOCK_EN
    do_reset();
    lock_step(4'h6, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0, 0);
    lock_step(4'h4, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0, 1);
    lock_step(4'h6, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0, 2);
    lock_step(4'h6, 4'h2, 4'h2, 1'b1, 2'd1, 1'b1, 3);
    lock_step(4'h6, 4'hF, 4'h4, 1'b1, 2'd2, 1'b1, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
